// File: rtl/ste_mem_pkg.sv
// Shared slot-timing constants and the 64-bit to 16-bit lane selector for the STE memory path.
// Purely declarative: no state, no timing of its own.
package ste_mem_pkg;

  localparam logic [1:0] SLOT_CYCLE = 2'd0;
  localparam logic [1:0] PH_LAST    = 2'd3;
  localparam logic [1:0] PRE_CYCLE  = 2'd3;
  localparam int         AW_DEF     = 23;

  function automatic logic [15:0] word_lane(input logic [63:0] data, input logic [1:0] sel);
    logic [15:0] w;
    case (sel)
      2'd0:    w = data[15:0];
      2'd1:    w = data[31:16];
      2'd2:    w = data[47:32];
      default: w = data[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ste_hslot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping N-1 -> 0.
// Zero latency; any=0 leaves onehot/idx at zero.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && mask[j]) begin
        any       = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ste_hslot_arbiter.sv
// Owns the hsync free RAM slot: picks one requester at bus_cycle 3/phase 3, holds read/saddr through
// bus_cycle 0, returns the addressed word with a one-cycle done 4 clk32 later; losers simply keep req high.
module ste_hslot_arbiter
  import ste_mem_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEF
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic [1:0]        bus_cycle,
  input  logic [1:0]        phase,
  input  logic              hsync,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   urgent,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [63:0]       data,
  output logic              read,
  output logic [AW-1:0]     saddr,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [15:0]       word_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            read_q, read_d;
  logic [AW-1:0]   saddr_q, saddr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [15:0]     word_q, word_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] u_oh, p_oh, win_oh;
  logic [PW-1:0]   u_idx, p_idx, win_idx;
  logic            u_any, p_any;
  logic            decide, capture;

  assign decide  = (bus_cycle == PRE_CYCLE)  && (phase == PH_LAST);
  assign capture = (bus_cycle == SLOT_CYCLE) && (phase == PH_LAST);

  rr_pick #(.N(NREQ), .PW(PW)) u_pick_urgent (
    .mask   (req & urgent),
    .ptr    (rr_ptr_q),
    .onehot (u_oh),
    .idx    (u_idx),
    .any    (u_any)
  );

  rr_pick #(.N(NREQ), .PW(PW)) u_pick_plain (
    .mask   (req),
    .ptr    (rr_ptr_q),
    .onehot (p_oh),
    .idx    (p_idx),
    .any    (p_any)
  );

  // Urgent requesters pre-empt the plain rotation but share the same pointer.
  assign win_oh  = u_any ? u_oh  : p_oh;
  assign win_idx = u_any ? u_idx : p_idx;

  always_comb begin
    read_d   = read_q;
    saddr_d  = saddr_q;
    grant_d  = grant_q;
    done_d   = '0;
    word_d   = word_q;
    rr_ptr_d = rr_ptr_q;
    if (decide) begin
      if (hsync && p_any) begin
        grant_d  = win_oh;
        saddr_d  = addr[int'(win_idx)*AW +: AW];
        read_d   = 1'b1;
        rr_ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      end else begin
        grant_d = '0;
        read_d  = 1'b0;
      end
    end else if (capture) begin
      if (grant_q != '0) begin
        word_d = word_lane(data, saddr_q[1:0]);
        done_d = grant_q;
      end
      grant_d = '0;
      read_d  = 1'b0;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      read_q   <= 1'b0;
      saddr_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      word_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      read_q   <= read_d;
      saddr_q  <= saddr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      word_q   <= word_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign read     = read_q;
  assign saddr    = saddr_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign word_out = word_q;

endmodule

// File: tb/tb_ste_hslot_arbiter.sv
// Directed bench for ste_hslot_arbiter: bus_cycle/phase sequencer plus hand-computed slot outcomes.
module tb_ste_hslot_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 23;

  logic              clk32;
  logic              reset;
  logic [1:0]        bus_cycle;
  logic [1:0]        phase;
  logic              hsync;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   urgent;
  logic [NREQ*AW-1:0] addr;
  logic [63:0]       data;
  logic              read;
  logic [AW-1:0]     saddr;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [15:0]       word_out;

  logic [3:0] pc;
  int checks;
  int failures;

  ste_hslot_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk32     (clk32),
    .reset     (reset),
    .bus_cycle (bus_cycle),
    .phase     (phase),
    .hsync     (hsync),
    .req       (req),
    .urgent    (urgent),
    .addr      (addr),
    .data      (data),
    .read      (read),
    .saddr     (saddr),
    .grant     (grant),
    .done      (done),
    .word_out  (word_out)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk32 edge; afterwards the next bus_cycle/phase is applied and outputs are stable.
  task automatic tick();
    @(posedge clk32);
    #1;
    pc        = pc + 4'd1;
    bus_cycle = pc[3:2];
    phase     = pc[1:0];
  endtask

  task automatic goto_pre();
    while (pc != 4'hF) tick();
  endtask

  task automatic do_slot(input string nm, input logic [2:0] eg, input logic [22:0] esa,
                         input logic [15:0] ew);
    goto_pre();
    tick();
    chk({nm, "_grant0"}, grant, eg);
    chk({nm, "_read0"}, read, eg != 3'b000);
    if (eg != 3'b000) chk({nm, "_saddr"}, saddr, esa);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk({nm, "_grant_hold"}, grant, eg);
      chk({nm, "_read_hold"}, read, eg != 3'b000);
    end
    tick();
    chk({nm, "_done"}, done, eg);
    chk({nm, "_grant_clr"}, grant, 3'b000);
    chk({nm, "_read_clr"}, read, 1'b0);
    if (eg != 3'b000) chk({nm, "_word"}, word_out, ew);
    tick();
    chk({nm, "_done_clr"}, done, 3'b000);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pc        = 4'd0;
    bus_cycle = 2'd0;
    phase     = 2'd0;
    reset     = 1'b1;
    hsync     = 1'b0;
    req       = '0;
    urgent    = '0;
    data      = 64'h4444_3333_2222_1111;
    addr      = {23'h000032, 23'h000021, 23'h000010};

    repeat (5) tick();
    chk("rst_read", read, 1'b0);
    chk("rst_grant", grant, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_saddr", saddr, 23'h0);
    chk("rst_word", word_out, 16'h0);
    reset = 1'b0;

    // Fairness: plain rotation from rr_ptr=0.
    hsync = 1'b1;
    req   = 3'b111;
    do_slot("fair0", 3'b001, 23'h000010, 16'h1111);
    do_slot("fair1", 3'b010, 23'h000021, 16'h2222);
    do_slot("fair2", 3'b100, 23'h000032, 16'h3333);
    do_slot("fair3", 3'b001, 23'h000010, 16'h1111);
    do_slot("fair4", 3'b010, 23'h000021, 16'h2222);
    do_slot("fair5", 3'b100, 23'h000032, 16'h3333);

    // No hsync: nothing granted, pointer stays at 0.
    hsync = 1'b0;
    req   = 3'b011;
    for (int s = 0; s < 10; s++) do_slot("nohs", 3'b000, 23'h0, 16'h0);
    hsync = 1'b1;
    do_slot("hs_rise", 3'b001, 23'h000010, 16'h1111);

    // Urgency (rr_ptr=1 here).
    req    = 3'b111;
    urgent = 3'b100;
    do_slot("urg_only2", 3'b100, 23'h000032, 16'h3333);
    urgent = 3'b000;
    do_slot("urg_plain", 3'b001, 23'h000010, 16'h1111);
    urgent = 3'b101;
    do_slot("urg_alt0", 3'b100, 23'h000032, 16'h3333);
    do_slot("urg_alt1", 3'b001, 23'h000010, 16'h1111);
    do_slot("urg_alt2", 3'b100, 23'h000032, 16'h3333);
    do_slot("urg_alt3", 3'b001, 23'h000010, 16'h1111);
    urgent = 3'b000;

    // Single requester, lane 2.
    addr[0 +: AW] = 23'h000102;
    req           = 3'b001;
    do_slot("single", 3'b001, 23'h000102, 16'h3333);

    // Late request: rises after the decision edge, waits a slot.
    req = 3'b000;
    goto_pre();
    tick();
    req = 3'b001;
    chk("late_grant", grant, 3'b000);
    chk("late_read", read, 1'b0);
    repeat (3) tick();
    chk("late_grant_hold", grant, 3'b000);
    tick();
    chk("late_done", done, 3'b000);
    do_slot("late_next", 3'b001, 23'h000102, 16'h3333);

    // Early drop: req1 released mid-slot still gets done.
    req = 3'b010;
    goto_pre();
    tick();
    chk("drop_grant", grant, 3'b010);
    chk("drop_saddr", saddr, 23'h000021);
    tick();
    req = 3'b000;
    tick();
    tick();
    chk("drop_grant_hold", grant, 3'b010);
    tick();
    chk("drop_done", done, 3'b010);
    chk("drop_word", word_out, 16'h2222);
    tick();
    chk("drop_done_clr", done, 3'b000);

    // Reset at slot phase 1 aborts the slot (rr_ptr was 2).
    req = 3'b111;
    goto_pre();
    tick();
    chk("mrst_grant_pre", grant, 3'b100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_read", read, 1'b0);
    chk("mrst_grant", grant, 3'b000);
    chk("mrst_done", done, 3'b000);
    chk("mrst_saddr", saddr, 23'h0);
    chk("mrst_word", word_out, 16'h0);
    tick();
    chk("mrst_capture_done", done, 3'b000);
    tick();
    chk("mrst_after_done", done, 3'b000);
    do_slot("mrst_next", 3'b001, 23'h000102, 16'h3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
